// File: rtl/button_conditioner_pkg.sv
// Shared constants for the pushbutton input stage: debounce FSM encodings,
// channel indices and default timing so the game top and the bench agree.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        HELD         = 2'd2,
        RELEASE_PEND = 2'd3
    } deb_state_e;

    localparam int DEF_TICK_DIV       = 25000;
    localparam int DEF_DEBOUNCE_TICKS = 10;
    localparam int DEF_CNT_W          = 4;

    localparam int CH_PAUSE    = 0;
    localparam int CH_NEW_GAME = 1;
    localparam int CH_UP       = 2;
    localparam int CH_DOWN     = 3;
    localparam int NUM_CH      = 4;

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One pushbutton channel: two-flop synchroniser feeding a tick-counted
// debounce FSM that reports the accepted level and a one-cycle press strobe.
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic btn_n,
    output logic level_n,
    output logic press_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    logic             sync_meta_q;
    logic             sync_n_q;
    deb_state_e       state_q;
    logic [CNT_W-1:0] count_q;
    logic             press_pulse_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta_q <= 1'b1;
            sync_n_q    <= 1'b1;
        end else begin
            sync_meta_q <= btn_n;
            sync_n_q    <= sync_meta_q;
        end
    end

    // Only a genuine press (PRESS_PEND -> HELD) strobes; a bounce during
    // release that drops back into HELD must not look like a new press.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RELEASED;
            count_q       <= '0;
            press_pulse_q <= 1'b0;
        end else begin
            press_pulse_q <= 1'b0;
            case (state_q)
                RELEASED: begin
                    if (!sync_n_q) begin
                        state_q <= PRESS_PEND;
                        count_q <= '0;
                    end
                end
                PRESS_PEND: begin
                    if (sync_n_q) begin
                        state_q <= RELEASED;
                        count_q <= '0;
                    end else if (tick) begin
                        if (count_q == CNT_LAST) begin
                            state_q       <= HELD;
                            count_q       <= '0;
                            press_pulse_q <= 1'b1;
                        end else begin
                            count_q <= count_q + CNT_W'(1);
                        end
                    end
                end
                HELD: begin
                    if (sync_n_q) begin
                        state_q <= RELEASE_PEND;
                        count_q <= '0;
                    end
                end
                RELEASE_PEND: begin
                    if (!sync_n_q) begin
                        state_q <= HELD;
                        count_q <= '0;
                    end else if (tick) begin
                        if (count_q == CNT_LAST) begin
                            state_q <= RELEASED;
                            count_q <= '0;
                        end else begin
                            count_q <= count_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= RELEASED;
                    count_q <= '0;
                end
            endcase
        end
    end

    assign level_n     = !((state_q == HELD) || (state_q == RELEASE_PEND));
    assign press_pulse = press_pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the four raw game buttons: shared debounce tick, per-button
// debounce channels, registered key levels, new-game strobe and pause toggle.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int TICK_DIV       = DEF_TICK_DIV,
    parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic pause_btn_n,
    input  logic new_game_btn_n,
    input  logic up_btn_n,
    input  logic down_btn_n,
    output logic pause_n,
    output logic new_game_n,
    output logic up_key_n,
    output logic down_key_n
);

    localparam int                PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]  prescaler_q;
    logic              tick;
    logic [NUM_CH-1:0] btn_n_vec;
    logic [NUM_CH-1:0] level_n_vec;
    logic [NUM_CH-1:0] pulse_vec;
    logic              paused_q;
    logic              paused_d;
    logic              pause_n_q;
    logic              new_game_n_q;
    logic              up_key_n_q;
    logic              down_key_n_q;
    logic              unused_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler_q <= '0;
        end else if (tick) begin
            prescaler_q <= '0;
        end else begin
            prescaler_q <= prescaler_q + PRE_W'(1);
        end
    end

    assign tick = (prescaler_q == PRE_LAST);

    assign btn_n_vec[CH_PAUSE]    = pause_btn_n;
    assign btn_n_vec[CH_NEW_GAME] = new_game_btn_n;
    assign btn_n_vec[CH_UP]       = up_btn_n;
    assign btn_n_vec[CH_DOWN]     = down_btn_n;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .tick        (tick),
            .btn_n       (btn_n_vec[gi]),
            .level_n     (level_n_vec[gi]),
            .press_pulse (pulse_vec[gi])
        );
    end

    // Pause and new-game only care about press strobes, the paddle keys only
    // about levels.
    assign unused_ok = &{1'b0, level_n_vec[CH_PAUSE], level_n_vec[CH_NEW_GAME],
                         pulse_vec[CH_UP], pulse_vec[CH_DOWN]};

    // Starting a new game always leaves the game running, even if pause was
    // pressed on the very same cycle.
    always_comb begin
        paused_d = paused_q;
        if (pulse_vec[CH_NEW_GAME]) begin
            paused_d = 1'b0;
        end else if (pulse_vec[CH_PAUSE]) begin
            paused_d = ~paused_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            paused_q     <= 1'b0;
            pause_n_q    <= 1'b1;
            new_game_n_q <= 1'b1;
            up_key_n_q   <= 1'b1;
            down_key_n_q <= 1'b1;
        end else begin
            paused_q     <= paused_d;
            pause_n_q    <= ~paused_d;
            new_game_n_q <= ~pulse_vec[CH_NEW_GAME];
            up_key_n_q   <= level_n_vec[CH_UP];
            down_key_n_q <= level_n_vec[CH_DOWN];
        end
    end

    assign pause_n    = pause_n_q;
    assign new_game_n = new_game_n_q;
    assign up_key_n   = up_key_n_q;
    assign down_key_n = down_key_n_q;

endmodule
